// File: rtl/md_pkg.sv
`default_nettype none
// ============================================================================
// Module  : md_pkg
// Purpose : Shared definitions for the multiply/divide scheduler: operation
//           encodings, fixed latencies, FSM state type and op classification.
//           Macro MD_MADD_EN enables op 7 (MADD) as a multicycle operation.
// Revision: 1.0 - initial release
// ============================================================================
package md_pkg;

    typedef logic [2:0] md_op_t;

    localparam md_op_t OP_NOP   = 3'd0;
    localparam md_op_t OP_MULT  = 3'd1;
    localparam md_op_t OP_MULTU = 3'd2;
    localparam md_op_t OP_DIV   = 3'd3;
    localparam md_op_t OP_DIVU  = 3'd4;
    localparam md_op_t OP_MTHI  = 3'd5;
    localparam md_op_t OP_MTLO  = 3'd6;
    localparam md_op_t OP_MADD  = 3'd7;

    localparam logic [3:0] MUL_LAT = 4'd5;
    localparam logic [3:0] DIV_LAT = 4'd10;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } md_state_t;

    // Ops that occupy the unit for several cycles and therefore stall D.
    function automatic logic is_multicycle(input md_op_t op);
        logic r;
        case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: r = 1'b1;
`ifdef MD_MADD_EN
            OP_MADD:                            r = 1'b1;
`endif
            default:                            r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] op_latency(input md_op_t op);
        return ((op == OP_DIV) || (op == OP_DIVU)) ? DIV_LAT : MUL_LAT;
    endfunction

endpackage
`default_nettype wire

// File: rtl/md_if.sv
`default_nettype none
// ============================================================================
// Module  : md_if
// Purpose : Bundle between the pipeline (master) and md_sched (slave).
//           master drives start/op/rs_val/rt_val/d_is_md;
//           slave drives busy/stall/hi/lo.
// Revision: 1.0 - initial release
// ============================================================================
interface md_if;
    import md_pkg::*;

    logic        start;
    md_op_t      op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        d_is_md;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, rs_val, rt_val, d_is_md,
        input  busy, stall, hi, lo
    );

    modport slave (
        input  start, op, rs_val, rt_val, d_is_md,
        output busy, stall, hi, lo
    );

endinterface
`default_nettype wire

// File: rtl/md_divider.sv
`default_nettype none
// ============================================================================
// Module  : md_divider
// Purpose : Combinational 32-bit signed/unsigned divide. Quotient truncates
//           toward zero, remainder takes the dividend's sign.
// Ports   : dividend, divisor, is_signed (in); quotient, remainder,
//           div_by_zero (out). Results are 0 when divisor is 0; the caller
//           uses div_by_zero to suppress the write-back.
// Revision: 1.0 - initial release
// ============================================================================
module md_divider (
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        is_signed,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_by_zero
);

    logic        w_neg_a;
    logic        w_neg_b;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [31:0] w_uq;
    logic [31:0] w_ur;

    assign w_neg_a     = is_signed & dividend[31];
    assign w_neg_b     = is_signed & divisor[31];
    assign w_abs_a     = w_neg_a ? (32'd0 - dividend) : dividend;
    assign w_abs_b     = w_neg_b ? (32'd0 - divisor)  : divisor;
    assign div_by_zero = (divisor == 32'd0);

    // 0x80000000 magnitude stays 0x80000000 as unsigned, so the
    // 0x80000000 / -1 case falls out as quotient 0x80000000, remainder 0.
    assign w_uq = div_by_zero ? 32'd0 : (w_abs_a / w_abs_b);
    assign w_ur = div_by_zero ? 32'd0 : (w_abs_a % w_abs_b);

    assign quotient  = (w_neg_a ^ w_neg_b) ? (32'd0 - w_uq) : w_uq;
    assign remainder = w_neg_a ? (32'd0 - w_ur) : w_ur;

endmodule
`default_nettype wire

// File: rtl/md_sched.sv
`default_nettype none
// ============================================================================
// Module  : md_sched
// Purpose : Multiply/divide unit scheduler with architectural HI/LO.
//           Multicycle ops latch operands, count down a fixed latency and
//           write HI/LO on the last busy cycle. MTHI/MTLO write directly.
// Ports   : clk, reset (sync, active-high); bus (md_if.slave):
//           start/op/rs_val/rt_val/d_is_md in, busy/stall/hi/lo out.
// Config  : MD_MADD_EN enables op 7 (MADD, 5-cycle accumulate).
// Revision: 1.0 - initial release
// ============================================================================
module md_sched
    import md_pkg::*;
(
    input  logic clk,
    input  logic reset,
    md_if.slave  bus
);

    md_state_t   r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_rs;
    logic [31:0] r_rt;
    md_op_t      r_op;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    md_state_t   w_state_nxt;
    logic [3:0]  w_cnt_nxt;
    logic        w_latch;
    logic        w_finish;
    logic        w_mthi;
    logic        w_mtlo;

    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic        w_dbz;

    // ---------------- arithmetic on latched operands ----------------
    assign w_prod_s = $signed({{32{r_rs[31]}}, r_rs}) * $signed({{32{r_rt[31]}}, r_rt});
    assign w_prod_u = {32'd0, r_rs} * {32'd0, r_rt};

`ifdef MD_MADD_EN
    logic [63:0] w_acc;
    assign w_acc = {r_hi, r_lo} + w_prod_s;
`endif

    md_divider u_div (
        .dividend    (r_rs),
        .divisor     (r_rt),
        .is_signed   (r_op == OP_DIV),
        .quotient    (w_quot),
        .remainder   (w_rem),
        .div_by_zero (w_dbz)
    );

    // ---------------- FSM state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // ---------------- FSM next state / control ----------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_latch     = 1'b0;
        w_finish    = 1'b0;
        w_mthi      = 1'b0;
        w_mtlo      = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    if (is_multicycle(bus.op)) begin
                        w_latch     = 1'b1;
                        w_cnt_nxt   = op_latency(bus.op);
                        w_state_nxt = RUN;
                    end
                    w_mthi = (bus.op == OP_MTHI);
                    w_mtlo = (bus.op == OP_MTLO);
                end
            end
            RUN: begin
                // start is ignored here; in-flight op runs to completion.
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_finish    = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // ---------------- operand latch and HI/LO ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rs <= 32'd0;
            r_rt <= 32'd0;
            r_op <= OP_NOP;
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else begin
            if (w_latch) begin
                r_rs <= bus.rs_val;
                r_rt <= bus.rt_val;
                r_op <= bus.op;
            end
            if (w_finish) begin
                case (r_op)
                    OP_MULT:  {r_hi, r_lo} <= w_prod_s;
                    OP_MULTU: {r_hi, r_lo} <= w_prod_u;
                    OP_DIV, OP_DIVU: begin
                        if (!w_dbz) begin
                            r_hi <= w_rem;
                            r_lo <= w_quot;
                        end
                    end
`ifdef MD_MADD_EN
                    OP_MADD:  {r_hi, r_lo} <= w_acc;
`endif
                    default: ;
                endcase
            end else if (w_mthi) begin
                r_hi <= bus.rs_val;
            end else if (w_mtlo) begin
                r_lo <= bus.rs_val;
            end
        end
    end

    assign bus.busy  = (r_state == RUN);
    assign bus.stall = bus.d_is_md & ((r_state == RUN) | (bus.start & is_multicycle(bus.op)));
    assign bus.hi    = r_hi;
    assign bus.lo    = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_md_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_md_sched
// Purpose : Directed self-checking bench for md_sched. Expected HI/LO values
//           are hand-computed; MADD expectations follow MD_MADD_EN.
// Revision: 1.0 - initial release
// ============================================================================
module tb_md_sched;
    import md_pkg::*;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    md_if intf ();

    md_sched dut (
        .clk   (clk),
        .reset (reset),
        .bus   (intf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic check_hilo(input string tag, input logic [31:0] ehi, input logic [31:0] elo);
        check({tag, " hi"}, {32'd0, intf.hi}, {32'd0, ehi});
        check({tag, " lo"}, {32'd0, intf.lo}, {32'd0, elo});
    endtask

    // Issue a multicycle op for one cycle, then check busy/stall over the
    // expected latency and that busy drops exactly afterwards.
    task automatic run_mc(input string tag, input md_op_t o, input logic [31:0] a,
                          input logic [31:0] b, input int lat, input logic dmd);
        intf.op      = o;
        intf.rs_val  = a;
        intf.rt_val  = b;
        intf.d_is_md = dmd;
        intf.start   = 1'b1;
        #1;
        check({tag, " issue stall"}, {63'd0, intf.stall}, {63'd0, dmd});
        check({tag, " issue busy"},  {63'd0, intf.busy},  64'd0);
        tick();
        intf.start = 1'b0;
        intf.op    = OP_NOP;
        #1;
        for (int i = 0; i < lat; i++) begin
            check($sformatf("%s busy c%0d", tag, i + 1),  {63'd0, intf.busy},  64'd1);
            check($sformatf("%s stall c%0d", tag, i + 1), {63'd0, intf.stall}, {63'd0, dmd});
            tick();
        end
        check({tag, " done busy"},  {63'd0, intf.busy},  64'd0);
        check({tag, " done stall"}, {63'd0, intf.stall}, 64'd0);
    endtask

    initial begin
        n_checks     = 0;
        n_pass       = 0;
        reset        = 1'b1;
        intf.start   = 1'b0;
        intf.op      = OP_NOP;
        intf.rs_val  = 32'd0;
        intf.rt_val  = 32'd0;
        intf.d_is_md = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst busy", {63'd0, intf.busy}, 64'd0);
        check("rst stall", {63'd0, intf.stall}, 64'd0);
        check_hilo("rst", 32'd0, 32'd0);
        intf.d_is_md = 1'b1;
        #1;
        check("rst stall dmd", {63'd0, intf.stall}, 64'd0);
        reset = 1'b0;
        tick();

        // MULT -2 * 3 with stall
        run_mc("mult", OP_MULT, 32'hFFFF_FFFE, 32'd3, 5, 1'b1);
        check_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

        // MULTU 0xFFFFFFFE * 3 without stall
        run_mc("multu", OP_MULTU, 32'hFFFF_FFFE, 32'd3, 5, 1'b0);
        check_hilo("multu", 32'h0000_0002, 32'hFFFF_FFFA);

        // DIV -7 / 2
        run_mc("div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 10, 1'b0);
        check_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        // DIVU 7 / 0 : unchanged, still 10 cycles
        run_mc("divu0", OP_DIVU, 32'd7, 32'd0, 10, 1'b0);
        check_hilo("divu0", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        // Signed overflow case
        run_mc("divovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 1'b0);
        check_hilo("divovf", 32'h0000_0000, 32'h8000_0000);

        // DIV 7 / -2 : q=-3, r=1
        run_mc("divneg", OP_DIV, 32'd7, 32'hFFFF_FFFE, 10, 1'b0);
        check_hilo("divneg", 32'h0000_0001, 32'hFFFF_FFFD);

        // DIVU 100 / 7 : q=14, r=2
        run_mc("divu", OP_DIVU, 32'd100, 32'd7, 10, 1'b0);
        check_hilo("divu", 32'h0000_0002, 32'h0000_000E);

        // Back-to-back: starts during RUN must be ignored
        intf.d_is_md = 1'b0;
        intf.op      = OP_MULT;
        intf.rs_val  = 32'd6;
        intf.rt_val  = 32'd7;
        intf.start   = 1'b1;
        tick();
        intf.op     = OP_DIV;
        intf.rs_val = 32'd100;
        intf.rt_val = 32'd3;
        tick();
        intf.op     = OP_MTHI;
        intf.rs_val = 32'hDEAD_BEEF;
        tick();
        intf.start = 1'b0;
        intf.op    = OP_NOP;
        tick();
        check("b2b busy c4", {63'd0, intf.busy}, 64'd1);
        tick();
        check("b2b busy c5", {63'd0, intf.busy}, 64'd1);
        tick();
        check("b2b busy end", {63'd0, intf.busy}, 64'd0);
        check_hilo("b2b", 32'd0, 32'd42);
        tick();
        check("b2b no restart", {63'd0, intf.busy}, 64'd0);
        check_hilo("b2b later", 32'd0, 32'd42);

        // MTHI in IDLE
        intf.op     = OP_MTHI;
        intf.rs_val = 32'h1234_5678;
        intf.start  = 1'b1;
        #1;
        check("mthi issue busy", {63'd0, intf.busy}, 64'd0);
        tick();
        intf.start = 1'b0;
        intf.op    = OP_NOP;
        check("mthi busy", {63'd0, intf.busy}, 64'd0);
        check_hilo("mthi", 32'h1234_5678, 32'd42);

        // MTLO 0xFFFFFFFF then MTHI 0 to set up accumulate
        intf.op     = OP_MTLO;
        intf.rs_val = 32'hFFFF_FFFF;
        intf.start  = 1'b1;
        tick();
        check("mtlo busy", {63'd0, intf.busy}, 64'd0);
        check_hilo("mtlo", 32'h1234_5678, 32'hFFFF_FFFF);
        intf.op     = OP_MTHI;
        intf.rs_val = 32'd0;
        tick();
        intf.start = 1'b0;
        check_hilo("mthi0", 32'd0, 32'hFFFF_FFFF);

        // NOP with start: no effect
        intf.op      = OP_NOP;
        intf.rs_val  = 32'h5555_5555;
        intf.d_is_md = 1'b1;
        intf.start   = 1'b1;
        #1;
        check("nop stall", {63'd0, intf.stall}, 64'd0);
        tick();
        intf.start = 1'b0;
        check("nop busy", {63'd0, intf.busy}, 64'd0);
        check_hilo("nop", 32'd0, 32'hFFFF_FFFF);

        // Op 7
`ifdef MD_MADD_EN
        run_mc("madd", OP_MADD, 32'd1, 32'd1, 5, 1'b1);
        check_hilo("madd", 32'd1, 32'd0);
`else
        intf.op     = OP_MADD;
        intf.rs_val = 32'd1;
        intf.rt_val = 32'd1;
        intf.start  = 1'b1;
        #1;
        check("op7 stall", {63'd0, intf.stall}, 64'd0);
        tick();
        intf.start = 1'b0;
        intf.op    = OP_NOP;
        check("op7 busy", {63'd0, intf.busy}, 64'd0);
        for (int i = 0; i < 6; i++) tick();
        check("op7 busy later", {63'd0, intf.busy}, 64'd0);
        check_hilo("op7", 32'd0, 32'hFFFF_FFFF);
`endif
        intf.d_is_md = 1'b0;

        // Reset in RUN cycle 3 of a DIV, reset beats a simultaneous start
        intf.op     = OP_DIV;
        intf.rs_val = 32'hFFFF_FFF9;
        intf.rt_val = 32'd2;
        intf.start  = 1'b1;
        tick();
        intf.start = 1'b0;
        intf.op    = OP_NOP;
        tick();
        tick();
        check("rstrun busy c3", {63'd0, intf.busy}, 64'd1);
        reset       = 1'b1;
        intf.start  = 1'b1;
        intf.op     = OP_MULT;
        intf.rs_val = 32'd5;
        intf.rt_val = 32'd5;
        tick();
        reset      = 1'b0;
        intf.start = 1'b0;
        intf.op    = OP_NOP;
        check("rstrun busy", {63'd0, intf.busy}, 64'd0);
        check_hilo("rstrun", 32'd0, 32'd0);
        tick();
        check("rstrun no start", {63'd0, intf.busy}, 64'd0);
        for (int i = 0; i < 12; i++) tick();
        check("rstrun busy later", {63'd0, intf.busy}, 64'd0);
        check_hilo("rstrun later", 32'd0, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/md_sched.md
MD_SCHED -- requirements
Module: md_sched

Interface
REQ-001 The block SHALL have input clk, 1 bit: the pipeline clock; all state updates on the rising edge.
REQ-002 The block SHALL have input reset, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have input start, 1 bit: E-stage holds a valid MD instruction this cycle.
REQ-004 The block SHALL have input op, 3 bits: MD operation; 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD.
REQ-005 The block SHALL have inputs rs_val and rt_val, 32 bits each: forwarded E-stage operands.
REQ-006 The block SHALL have input d_is_md, 1 bit: D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo/madd.
REQ-007 The block SHALL have output busy, 1 bit: a multicycle operation is in flight.
REQ-008 The block SHALL have output stall, 1 bit: D-stage pipe register holds, E-stage pipe register is flushed.
REQ-009 The block SHALL have outputs hi and lo, 32 bits each: architectural HI/LO registers.

Function
REQ-010 The block SHALL have FSM states IDLE and RUN; busy SHALL equal (state==RUN).
REQ-011 In IDLE, start with op in {MULT, MULTU, DIV, DIVU, MADD-if-enabled} SHALL latch rs_val, rt_val and op, load counter with N, and enter RUN.
REQ-012 N SHALL be 5 for MULT/MULTU/MADD and 10 for DIV/DIVU.
REQ-013 In RUN the counter SHALL decrement each cycle; at the edge where counter==1, hi/lo SHALL be written and state SHALL return to IDLE.
REQ-014 As a result, busy SHALL be high for exactly N cycles, and new hi/lo SHALL be visible in the first cycle busy is low.
REQ-015 MULT and MULTU SHALL produce {hi,lo} = 64-bit signed and unsigned product, respectively.
REQ-016 DIV and DIVU SHALL produce lo=quotient and hi=remainder; quotient truncates toward zero; remainder takes the sign of the dividend.
REQ-017 Signed 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0.
REQ-018 Division by zero SHALL leave hi/lo unchanged, while still running the full 10-cycle latency.
REQ-019 MTHI/MTLO with start in IDLE SHALL write rs_val to hi/lo at the next edge, with no busy.
REQ-020 start while in RUN SHALL be ignored, and any in-flight operation SHALL be unaffected.
REQ-021 stall SHALL be combinational: d_is_md & (busy | (start & op in the multicycle set)).
REQ-022 op NOP, or op 7 with MADD disabled, SHALL have no effect.

Reset
REQ-023 On reset: state=IDLE, counter=0, hi=0, lo=0, latched operands=0, and busy=0; stall SHALL follow REQ-021 with busy=0.
REQ-024 Reset during RUN SHALL abort the operation, with no hi/lo write-back.
REQ-025 Reset SHALL take priority over start in the same cycle.

Configuration
REQ-026 Macro MD_MADD_EN defined: op 7 MADD SHALL perform {hi,lo} <= {hi,lo} + signed(rs_val)*signed(rt_val), modulo 2^64, with 5-cycle latency.
REQ-027 MD_MADD_EN undefined: op 7 SHALL be treated as NOP, and no accumulate logic SHALL be synthesized.

Structure
REQ-028 Shared package md_pkg SHALL hold the op encodings, the constants MUL_LAT=5 and DIV_LAT=10, and the state enumeration.
REQ-029 Arithmetic SHALL be combinational on the latched operands, inside md_sched.
REQ-030 One sub-module, md_divider (signed/unsigned quotient/remainder with the REQ-016..018 rules), is natural and SHALL be used.

Verification
REQ-031 MULT test: MULT rs=0xFFFFFFFE, rt=3 -> busy 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-032 DIV test: DIV rs=-7, rt=2 -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/0 -> hi/lo unchanged after 10 cycles.
REQ-033 Stall test: MULT issued with d_is_md=1 -> stall=1 in the issue cycle and all 5 busy cycles, then 0; with d_is_md=0 -> stall=0 throughout.
REQ-034 Reset test: reset asserted in RUN cycle 3 of a DIV -> next cycle busy=0, hi=lo=0, and no later write.
REQ-035 Back-to-back/idle-write test: start in RUN ignored, checked by hi/lo equal to the first op only; MTHI 0x12345678 in IDLE -> hi=0x12345678 next cycle, busy never 1.
REQ-036 MADD test (MD_MADD_EN): {hi,lo}=0x0:0xFFFFFFFF, MADD 1*1 -> hi=1, lo=0; without macro, op 7 leaves hi/lo unchanged.
